// File: rtl/series_eval_engine.sv
// Fixed-point power-series evaluator: y = sum s_k*c_k*x^(2k+p), external coefficient LUT.
// Define SERIES_SAT_EN to saturate product/accumulator overflow instead of wrapping.
module series_eval_engine #(
    parameter int WIDTH     = 16,
    parameter int FRAC      = 12,
    parameter int MAX_TERMS = 8,
    localparam int AW = $clog2(MAX_TERMS),
    localparam int NW = $clog2(MAX_TERMS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x,
    input  logic [NW-1:0]           n_terms,
    input  logic                    alt_sign,
    input  logic                    odd_pow,
    output logic [AW-1:0]           coef_addr,
    input  logic signed [WIDTH-1:0] coef_data,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] y,
    output logic                    ovf
);

    localparam logic [NW-1:0]    MAX_N = NW'(MAX_TERMS);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1 << FRAC);
    localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StSqr, StMulC, StAcc, StMulX, StDone} state_e;

    state_e state_q, state_d;

    logic [AW-1:0]           k_q;
    logic [NW-1:0]           n_q;
    logic                    alt_q, odd_q, ovf_q;
    logic signed [WIDTH-1:0] x_q, x2_q, p_q, t_q, acc_q, y_q;

    // Result packed as {overflow, value}.
    function automatic logic [WIDTH:0] q_mul(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] prod;
        logic signed [2*WIDTH-1:0] sh;
        logic                      ov;
        logic [WIDTH-1:0]          res;
        prod = a * b;
        sh   = prod >>> FRAC;
        // Kept value is valid only if everything above it is a sign extension.
        ov   = sh[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){sh[2*WIDTH-1]}};
        res  = sh[WIDTH-1:0];
`ifdef SERIES_SAT_EN
        if (ov) res = sh[2*WIDTH-1] ? Q_MIN : Q_MAX;
`endif
        return {ov, res};
    endfunction

    function automatic logic [WIDTH:0] q_add(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b,
                                             input logic                    sub);
        logic [WIDTH:0]   ext;
        logic             ov;
        logic [WIDTH-1:0] res;
        ext = sub ? ({a[WIDTH-1], a} - {b[WIDTH-1], b}) : ({a[WIDTH-1], a} + {b[WIDTH-1], b});
        ov  = ext[WIDTH] ^ ext[WIDTH-1];
        res = ext[WIDTH-1:0];
`ifdef SERIES_SAT_EN
        if (ov) res = ext[WIDTH] ? Q_MIN : Q_MAX;
`endif
        return {ov, res};
    endfunction

    logic [NW-1:0]  n_eff;
    logic           last_term;
    logic [WIDTH:0] sq_r, pc_r, px_r, add_r;

    assign n_eff     = (n_terms > MAX_N) ? MAX_N : n_terms;
    assign last_term = (NW'(k_q) + NW'(1)) == n_q;
    assign sq_r      = q_mul(x_q, x_q);
    assign pc_r      = q_mul(p_q, coef_data);
    assign px_r      = q_mul(p_q, x2_q);
    assign add_r     = q_add(acc_q, t_q, alt_q && k_q[0]);

    assign coef_addr = k_q;
    assign y         = y_q;
    assign ovf       = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = (n_eff != '0) ? StSqr : StDone;
            StSqr:  state_d = StMulC;
            StMulC: state_d = StAcc;
            StAcc:  state_d = last_term ? StDone : StMulX;
            StMulX: state_d = StMulC;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            StIdle: ;
            StDone: done = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q   <= '0;
            n_q   <= '0;
            alt_q <= 1'b0;
            odd_q <= 1'b0;
            ovf_q <= 1'b0;
            x_q   <= '0;
            x2_q  <= '0;
            p_q   <= '0;
            t_q   <= '0;
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        ovf_q <= 1'b0;
                        if (n_eff != '0) begin
                            x_q   <= x;
                            n_q   <= n_eff;
                            alt_q <= alt_sign;
                            odd_q <= odd_pow;
                            acc_q <= '0;
                            k_q   <= '0;
                        end else begin
                            y_q <= '0;
                        end
                    end
                end
                StSqr: begin
                    x2_q  <= sq_r[WIDTH-1:0];
                    ovf_q <= ovf_q | sq_r[WIDTH];
                    p_q   <= odd_q ? x_q : ONE;
                end
                StMulC: begin
                    t_q   <= pc_r[WIDTH-1:0];
                    ovf_q <= ovf_q | pc_r[WIDTH];
                end
                StAcc: begin
                    acc_q <= add_r[WIDTH-1:0];
                    ovf_q <= ovf_q | add_r[WIDTH];
                    if (last_term) y_q <= add_r[WIDTH-1:0];
                    else           k_q <= k_q + AW'(1);
                end
                StMulX: begin
                    p_q   <= px_r[WIDTH-1:0];
                    ovf_q <= ovf_q | px_r[WIDTH];
                end
                default: ;
            endcase
        end
    end

endmodule
